chacha_xor_stream: RTL and testbench

Consumer end of the ChaCha20 keystream interface. It sinks 512-bit keystream pads on an Avalon-ST sink and buffers one pad at a time. It XORs the pad, one 32-bit word at a time, onto an incoming Avalon-ST data stream and emits ciphertext or plaintext on an Avalon-ST source. Avalon-MM CSRs let Nios II or ARM read status and counters and flush a partially used pad.

---
 rtl/chacha_xor_stream_pkg.sv | 51 +++++
 rtl/chacha_xor_stream_slicer.sv | 71 +++++++
 rtl/chacha_xor_stream.sv | 127 ++++++++++++
 tb/tb_chacha_xor_stream.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_xor_stream_pkg.sv
// Shared definitions for the ChaCha20 keystream path: word/pad types,
// CSR map and CONTROL bit positions used by the generator and the consumer.
package chacha_xor_stream_pkg;

    localparam int WORD_W        = 32;
    localparam int WORDS_PER_PAD = 16;

    typedef logic [WORD_W-1:0]               Word_t;
    typedef logic [WORD_W*WORDS_PER_PAD-1:0] RawState_t;
    typedef logic [3:0]                      WordIdx_t;

    localparam WordIdx_t LAST_WORD_IDX = 4'(WORDS_PER_PAD - 1);

    // CSR register select values
    localparam logic [1:0] CSR_STATUS  = 2'd0;
    localparam logic [1:0] CSR_WORDS   = 2'd1;
    localparam logic [1:0] CSR_PADS    = 2'd2;
    localparam logic [1:0] CSR_CONTROL = 2'd3;

    // CONTROL register bit positions
    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_CLRCNT_BIT = 1;

    // Pad slot state: a pad is either waiting to be consumed or the slot is free
    typedef enum logic {
        SLOT_EMPTY  = 1'b0,
        SLOT_LOADED = 1'b1
    } slot_state_t;

    // STATUS register layout
    typedef struct packed {
        logic [23:0] reserved_hi;
        WordIdx_t    word_idx;
        logic [1:0]  reserved_lo;
        logic        out_valid;
        logic        pad_loaded;
    } Status_t;

    // Select word idx of a pad; word i lives at bits [32*i +: 32]
    function automatic Word_t pad_word(input RawState_t pad, input WordIdx_t idx);
        Word_t w;
        w = '0;
        for (int i = 0; i < WORDS_PER_PAD; i++) begin
            if (idx == WordIdx_t'(i)) begin
                w = pad[i*WORD_W +: WORD_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/chacha_xor_stream_slicer.sv
// Holds one keystream pad and presents it as a stream of 32-bit words.
// A pad is only accepted when the slot is empty; a word is consumed when
// word_valid && word_ready. The slot empties after the last word of the pad,
// after a word flagged word_last, or on flush. A pad accept wins over flush.
module chacha_pad_slicer
    import chacha_xor_stream_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  RawState_t   pad_data,
    input  logic        pad_valid,
    output logic        pad_ready,
    output Word_t       word_data,
    output logic        word_valid,
    input  logic        word_ready,
    input  logic        word_last,
    input  logic        flush,
    output WordIdx_t    word_idx,
    output logic        pad_accept,
    output slot_state_t slot_state
);

    RawState_t   pad_buf;
    slot_state_t state_q, state_d;
    WordIdx_t    idx_q, idx_d;
    logic        word_take;
    logic        pad_done;

    assign pad_ready  = (state_q == SLOT_EMPTY);
    assign pad_accept = pad_valid && pad_ready;
    assign word_valid = (state_q == SLOT_LOADED);
    assign word_take  = word_valid && word_ready;
    assign pad_done   = word_take && (word_last || (idx_q == LAST_WORD_IDX));
    assign word_data  = pad_word(pad_buf, idx_q);
    assign word_idx   = idx_q;
    assign slot_state = state_q;

    // Pad storage: only rewritten when a new pad is taken into the empty slot
    always_ff @(posedge clock) begin
        if (pad_accept) begin
            pad_buf <= pad_data;
        end
    end

    // Slot state and word pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next slot state: load, discard (flush / end of pad / end of message), advance
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (pad_accept) begin
            state_d = SLOT_LOADED;
            idx_d   = '0;
        end else if (flush || pad_done) begin
            state_d = SLOT_EMPTY;
            idx_d   = '0;
        end else if (word_take) begin
            idx_d = idx_q + 4'd1;
        end
    end

endmodule

// File: rtl/chacha_xor_stream.sv
// Consumer end of the ChaCha20 keystream: XORs buffered pad words onto an
// Avalon-ST data stream, with Avalon-MM status/counter/flush registers.
//
// Handshakes: every stream moves one beat on a cycle where valid && ready.
// Valid never depends combinationally on ready of the same interface; ready
// may depend on local state and on downstream ready (in_ready follows
// out_ready through the single output register).
module chacha_xor_stream
    import chacha_xor_stream_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [511:0]      pad_data,
    input  logic              pad_valid,
    output logic              pad_ready,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [1:0]        csr_address,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata
);

    Word_t              key_word;
    logic               key_valid;
    WordIdx_t           word_idx;
    logic               pad_accept;
    slot_state_t        slot_state;
    logic               out_free;
    logic               in_take;
    logic               out_beat;
    logic               ctrl_write;
    logic               flush;
    logic               clrcnt;
    logic [COUNT_W-1:0] word_count;
    logic [COUNT_W-1:0] pad_count;
    Status_t            status;
    logic               unused_ctrl_bits;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = key_valid && out_free;
    assign in_take    = in_valid && in_ready;
    assign out_beat   = out_valid && out_ready;
    assign ctrl_write = csr_write && (csr_address == CSR_CONTROL);
    assign flush      = ctrl_write && csr_writedata[CTRL_FLUSH_BIT];
    assign clrcnt     = ctrl_write && csr_writedata[CTRL_CLRCNT_BIT];

    assign unused_ctrl_bits = ^csr_writedata[31:2];

    chacha_pad_slicer u_slicer (
        .clock      (clock),
        .reset      (reset),
        .pad_data   (pad_data),
        .pad_valid  (pad_valid),
        .pad_ready  (pad_ready),
        .word_data  (key_word),
        .word_valid (key_valid),
        .word_ready (in_valid && out_free),
        .word_last  (in_last),
        .flush      (flush),
        .word_idx   (word_idx),
        .pad_accept (pad_accept),
        .slot_state (slot_state)
    );

    // Output register: load on input accept, drop valid once the beat is taken
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_take) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ key_word;
            out_last  <= in_last;
        end else if (out_beat) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-word and accepted-pad counters; a clear wins over a count
    always_ff @(posedge clock) begin
        if (reset || clrcnt) begin
            word_count <= '0;
            pad_count  <= '0;
        end else begin
            if (out_beat) begin
                word_count <= word_count + COUNT_W'(1);
            end
            if (pad_accept) begin
                pad_count <= pad_count + COUNT_W'(1);
            end
        end
    end

    // STATUS layout assembly
    always_comb begin
        status            = '0;
        status.word_idx   = word_idx;
        status.out_valid  = out_valid;
        status.pad_loaded = (slot_state == SLOT_LOADED);
    end

    // Registered CSR read data; holds its value between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                CSR_STATUS: csr_readdata <= status;
                CSR_WORDS:  csr_readdata <= 32'(word_count);
                CSR_PADS:   csr_readdata <= 32'(pad_count);
                default:    csr_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Bench for chacha_xor_stream: queue-driven pad/data/CSR traffic checked
// every cycle against a transaction-level model of the keystream slot.
`timescale 1ns/1ps
module tb_chacha_xor_stream;

  logic         clock;
  logic         reset;
  logic [511:0] pad_data;
  logic         pad_valid;
  logic         pad_ready;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         csr_read;
  logic         csr_write;
  logic [1:0]   csr_address;
  logic [31:0]  csr_writedata;
  logic [31:0]  csr_readdata;

  chacha_xor_stream #(.COUNT_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .pad_data      (pad_data),
    .pad_valid     (pad_valid),
    .pad_ready     (pad_ready),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_address   (csr_address),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus queues / driver controls ----------------
  logic [511:0] pad_q[$];
  logic [32:0]  in_q[$];        // {last, data}
  bit           pad_taken;
  bit           in_taken;
  int           ready_mode;     // 0: always ready, 1: random, 2: held low
  bit           in_gaps;
  bit           auto_pad;

  function automatic logic [511:0] rand_pad();
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  // Pad source: presents the queue head until the model sees it accepted
  initial begin
    pad_valid = 1'b0;
    pad_data  = '0;
    forever begin
      @(posedge clock); #1;
      if (pad_taken && pad_q.size() > 0) void'(pad_q.pop_front());
      if (auto_pad && pad_q.size() == 0) pad_q.push_back(rand_pad());
      if (pad_q.size() > 0) begin
        pad_valid = 1'b1;
        pad_data  = pad_q[0];
      end else begin
        pad_valid = 1'b0;
      end
    end
  end

  // Data source: presents queued words, optionally with idle gaps
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (in_taken && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0 && !(in_gaps && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b1;
        {in_last, in_data} = in_q[0];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
  end

  // Downstream ready pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // The slot holds at most one pad; each pad word is used once, in order.
  logic [31:0] m_pad[16];
  bit          m_loaded;
  logic [3:0]  m_idx;
  logic [31:0] m_words;
  logic [31:0] m_pads;
  logic [31:0] m_rd;
  logic [32:0] exp_q[$];        // expected output beats {last, data}
  int          bubbles;
  bit          exp_ov, exp_in_ready, out_hs, in_acc, pad_acc, m_flush, m_clr;

  initial begin
    m_loaded = 1'b0; m_idx = '0; m_words = '0; m_pads = '0; m_rd = '0;
    bubbles = 0; pad_taken = 1'b0; in_taken = 1'b0;
  end

  // Outputs are sampled mid-cycle; the model then advances to the next edge
  always @(negedge clock) begin
    exp_ov       = (exp_q.size() != 0);
    exp_in_ready = m_loaded && (!exp_ov || out_ready);
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check_eq("out_data", out_data, exp_q[0][31:0]);
      check_eq("out_last", 32'(out_last), 32'(exp_q[0][32]));
    end
    check_eq("pad_ready", 32'(pad_ready), 32'(!m_loaded));
    check_eq("in_ready", 32'(in_ready), 32'(exp_in_ready));
    check_eq("csr_readdata", csr_readdata, m_rd);

    out_hs  = exp_ov && out_ready;
    in_acc  = in_valid && exp_in_ready;
    pad_acc = pad_valid && !m_loaded;
    m_flush = csr_write && csr_address == 2'd3 && csr_writedata[0];
    m_clr   = csr_write && csr_address == 2'd3 && csr_writedata[1];

    if (reset) begin
      m_loaded = 1'b0; m_idx = '0; m_words = '0; m_pads = '0; m_rd = '0;
      exp_q.delete();
      pad_taken = 1'b0;
      in_taken  = 1'b0;
    end else begin
      if (in_valid && !exp_in_ready) bubbles++;
      if (csr_read) begin
        case (csr_address)
          2'd0:    m_rd = {24'b0, m_idx, 2'b0, exp_ov, m_loaded};
          2'd1:    m_rd = m_words;
          2'd2:    m_rd = m_pads;
          default: m_rd = '0;
        endcase
      end
      if (out_hs) begin
        void'(exp_q.pop_front());
        m_words = m_words + 1;
      end
      if (in_acc) begin
        exp_q.push_back({in_last, in_data ^ m_pad[m_idx]});
        if (m_idx == 4'd15 || in_last) begin
          m_loaded = 1'b0;
          m_idx    = '0;
        end else begin
          m_idx = m_idx + 4'd1;
        end
      end
      if (m_flush) begin
        m_loaded = 1'b0;
        m_idx    = '0;
      end
      if (pad_acc) begin
        for (int k = 0; k < 16; k++) m_pad[k] = pad_data[k*32 +: 32];
        m_loaded = 1'b1;
        m_idx    = '0;
        m_pads   = m_pads + 1;
      end
      if (m_clr) begin
        m_words = '0;
        m_pads  = '0;
      end
      pad_taken = pad_acc;
      in_taken  = in_acc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic csr_rd(input logic [1:0] addr, output logic [31:0] data);
    @(posedge clock); #2;
    csr_read    = 1'b1;
    csr_address = addr;
    @(posedge clock); #2;
    csr_read = 1'b0;
    data     = csr_readdata;
  endtask

  task automatic csr_wr(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clock); #2;
    csr_write     = 1'b1;
    csr_address   = addr;
    csr_writedata = data;
    @(posedge clock); #2;
    csr_write = 1'b0;
  endtask

  task automatic push_msg(input int len, input bit with_last);
    for (int i = 0; i < len; i++)
      in_q.push_back({(with_last && i == len - 1), 32'($urandom())});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock); #2;
      if (in_q.size() == 0 && exp_q.size() == 0 && !in_valid) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock); #2;
      if (exp_q.size() != 0) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_loaded(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock); #2;
      if (m_loaded) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  logic [31:0]  rd;
  logic [511:0] ramp_pad;
  logic [7:0]   bval;

  initial begin
    reset = 1'b1;
    csr_read = 1'b0; csr_write = 1'b0; csr_address = '0; csr_writedata = '0;
    ready_mode = 0; in_gaps = 1'b0; auto_pad = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // reset state
    check_eq("rst_pad_ready", 32'(pad_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_readdata", csr_readdata, 32'd0);

    // ramp pad, zero data: output equals the pad words in order
    for (int i = 0; i < 16; i++) begin
      bval = 8'(i);
      ramp_pad[i*32 +: 32] = {4{bval}};
    end
    pad_q.push_back(ramp_pad);
    for (int i = 0; i < 16; i++) in_q.push_back({1'b0, 32'h0});
    wait_drain("ramp_drain", 200);
    csr_rd(2'd1, rd); check_eq("ramp_words", rd, 32'd16);
    csr_rd(2'd2, rd); check_eq("ramp_pads", rd, 32'd1);

    // two pads back to back: exactly one reload bubble
    pad_q.push_back(rand_pad());
    wait_loaded("b2b_load", 50);
    pad_q.push_back(rand_pad());
    bubbles = 0;
    push_msg(32, 1'b0);
    wait_drain("b2b_drain", 200);
    check_eq("b2b_bubbles", 32'(bubbles), 32'd1);

    // early last on word 5 discards the rest of the pad
    pad_q.push_back(rand_pad());
    push_msg(5, 1'b0);
    in_q.push_back({1'b1, 32'hFFFF_FFFF});
    pad_q.push_back(rand_pad());
    push_msg(3, 1'b1);
    wait_drain("last_drain", 200);
    check_eq("last_pad_ready", 32'(pad_ready), 32'd1);

    // downstream stall holds the output and the word pointer
    ready_mode = 2;
    pad_q.push_back(rand_pad());
    push_msg(4, 1'b0);
    wait_out_valid("stall_ov", 50);
    csr_rd(2'd0, rd);
    check_eq("stall_status", rd, 32'h0000_0013);
    repeat (2) @(posedge clock);
    #2 check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 0;
    wait_drain("stall_drain", 200);
    csr_wr(2'd3, 32'd1);

    // flush a partly used pad, next pad starts at word 0, then clear counters
    pad_q.push_back(rand_pad());
    push_msg(3, 1'b0);
    wait_drain("flush_drain", 200);
    csr_wr(2'd3, 32'd1);
    csr_rd(2'd0, rd);
    check_eq("flush_status", rd, 32'd0);
    pad_q.push_back(rand_pad());
    push_msg(4, 1'b1);
    wait_drain("flush_next", 200);
    csr_wr(2'd3, 32'd2);
    csr_rd(2'd1, rd); check_eq("clr_words", rd, 32'd0);
    csr_rd(2'd2, rd); check_eq("clr_pads", rd, 32'd0);

    // reset in the middle of a stalled, half-used pad
    ready_mode = 2;
    pad_q.push_back(rand_pad());
    push_msg(6, 1'b0);
    wait_out_valid("mid_ov", 50);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    in_q.delete();
    pad_q.delete();
    @(posedge clock);
    #2 reset = 1'b0;
    ready_mode = 0;
    check_eq("mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_pad_ready", 32'(pad_ready), 32'd1);
    csr_rd(2'd1, rd); check_eq("mid_words", rd, 32'd0);
    csr_rd(2'd2, rd); check_eq("mid_pads", rd, 32'd0);

    // randomized traffic with CSR activity interleaved
    ready_mode = 1;
    in_gaps    = 1'b1;
    auto_pad   = 1'b1;
    for (int m = 0; m < 10; m++) begin
      push_msg($urandom_range(1, 40), 1'b1);
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 3) == 0)
          csr_wr(2'($urandom_range(0, 3)), $urandom());
        else
          csr_rd(2'($urandom_range(0, 3)), rd);
      end
      wait_drain("rand_drain", 2000);
    end
    auto_pad = 1'b0;
    repeat (4) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
